wb_daq_write_sequencer: RTL and testbench

Upstream command source for the DAQ Wishbone bus master. It drains ADC samples from the DAQ sample FIFO and issues one single-word Wishbone write per sample, through the bus master's start/address/selection/write/data_wr command interface. Samples land in a memory frame buffer at base_address, and the block reports frame completion. Configuration comes from the same control_reg word the bus master receives.

---
 rtl/wb_daq_write_sequencer.sv | 107 ++++++++++
 tb/tb_wb_daq_write_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_daq_write_sequencer.sv
// wb_daq_write_sequencer: drains DAQ FIFO samples into single-word Wishbone writes to a frame buffer
module wb_daq_write_sequencer #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst,
    input  logic [dw-1:0] i_control_reg,
    input  logic [aw-1:0] i_base_address,
    input  logic          i_fifo_empty,
    output logic          o_fifo_rd,
    input  logic [dw-1:0] i_fifo_data,
    input  logic          i_active,
    output logic          o_start,
    output logic [aw-1:0] o_address,
    output logic [3:0]    o_selection,
    output logic          o_write,
    output logic [dw-1:0] o_data_wr,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic [15:0]   o_word_index
);
    typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_ACT, WAIT_DONE} state_t;

    state_t        r_state, w_next;
    logic          r_en_d, r_armed, r_write, r_frame_done;
    logic [15:0]   r_word_index, r_len_d;
    logic [3:0]    r_selection;
    logic [aw-1:0] r_address;
    logic [dw-1:0] r_data_wr;

    logic          w_en, w_cont, w_done, w_last;
    logic [15:0]   w_len;
    logic          w_unused_ctrl;

    assign w_en          = i_control_reg[0];
    assign w_cont        = i_control_reg[1];
    assign w_len         = i_control_reg[31:16];
    assign w_unused_ctrl = ^i_control_reg[15:2];
    assign w_done        = (r_state == WAIT_DONE) && !i_active;
    // word_index >= length-1, evaluated against the live length so a shrink ends the frame
    assign w_last        = ({1'b0, r_word_index} + 17'd1) >= {1'b0, w_len};

    assign o_fifo_rd    = (r_state == FETCH);
    assign o_start      = (r_state == ISSUE);
    assign o_busy       = (r_state != IDLE);
    assign o_address    = r_address;
    assign o_selection  = r_selection;
    assign o_write      = r_write;
    assign o_data_wr    = r_data_wr;
    assign o_frame_done = r_frame_done;
    assign o_word_index = r_word_index;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (r_armed && w_en && !i_fifo_empty) w_next = FETCH;
            FETCH:     w_next = LATCH;
            LATCH:     w_next = ISSUE;
            ISSUE:     w_next = WAIT_ACT;
            WAIT_ACT:  if (i_active) w_next = WAIT_DONE;
            WAIT_DONE: if (!i_active) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk) begin
        if (!i_wb_rst) begin
            r_state      <= IDLE;
            r_en_d       <= 1'b1;
            r_armed      <= 1'b0;
            r_len_d      <= '0;
            r_word_index <= '0;
            r_address    <= '0;
            r_data_wr    <= '0;
            r_selection  <= '0;
            r_write      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_en_d       <= w_en;
            r_len_d      <= w_len;
            r_frame_done <= w_done && w_last;
            if (!w_en)
                r_armed <= 1'b0;
            else if (!r_en_d && w_len != 16'd0)
                r_armed <= 1'b1;
            else if (w_done && w_last && !w_cont)
                r_armed <= 1'b0;
            // a new length written while idle restarts the frame at word 0
            if (w_done)
                r_word_index <= w_last ? 16'd0 : r_word_index + 16'd1;
            else if (r_state == IDLE && w_len != r_len_d)
                r_word_index <= '0;
            if (r_state == LATCH) begin
                r_data_wr   <= i_fifo_data;
                r_address   <= i_base_address + aw'(r_word_index) * aw'(ADDR_STEP);
                r_selection <= 4'hF;
                r_write     <= 1'b1;
            end else if (w_done || r_state == IDLE) begin
                r_selection <= '0;
                r_write     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_daq_write_sequencer.sv
// tb_wb_daq_write_sequencer: scenario table, randomized frames and hand-written corner cases
module tb_wb_daq_write_sequencer;
    localparam logic [31:0] STEP = 32'd4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] ctrl = '0, base = '0, fifo_data = '0;
    logic        fifo_empty = 1'b1, active = 1'b0;
    logic [1:0]  act_cnt = '0;
    logic        fifo_rd, start, write, busy, frame_done;
    logic [31:0] address, data_wr;
    logic [3:0]  sel;
    logic [15:0] widx;

    typedef struct {logic [31:0] a; logic [31:0] d;} txn_t;
    typedef struct {logic [31:0] base; logic [15:0] len; logic cont; int n; int xs; int xf; logic [15:0] xi;} vec_t;

    txn_t        exp_q[$];
    logic [31:0] fq[$];
    vec_t        tbl[6];
    int          n_cmp = 0, n_fail = 0, n_start = 0, n_rd = 0, n_fd = 0;

    wb_daq_write_sequencer dut (
        .i_wb_clk(clk), .i_wb_rst(rst_n), .i_control_reg(ctrl), .i_base_address(base),
        .i_fifo_empty(fifo_empty), .o_fifo_rd(fifo_rd), .i_fifo_data(fifo_data),
        .i_active(active), .o_start(start), .o_address(address), .o_selection(sel),
        .o_write(write), .o_data_wr(data_wr), .o_busy(busy), .o_frame_done(frame_done),
        .o_word_index(widx)
    );

    always #5 clk = ~clk;

    // bus master: active rises the cycle after start and stays high for 3 cycles
    always @(posedge clk) begin
        if (start) begin
            active  <= 1'b1;
            act_cnt <= 2'd2;
        end else if (act_cnt != 0) act_cnt <= act_cnt - 2'd1;
        else active <= 1'b0;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic fifo_proc();
        forever begin
            @(posedge clk);
            if (fifo_rd && fq.size() != 0) begin
                fifo_data  = fq.pop_front();
                fifo_empty = (fq.size() == 0);
            end
        end
    endtask

    task automatic mon();
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (start) begin
                    n_start++;
                    chk("start_expected", 64'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("address", address, e.a);
                        chk("data_wr", data_wr, e.d);
                        chk("sel_write", {sel, write}, 5'h1F);
                    end
                end
                if (fifo_rd) n_rd++;
                if (frame_done) n_fd++;
            end
        end
    endtask

    task automatic setup(input logic [31:0] b, input logic [15:0] len, input logic c);
        rst_n = 1'b0;
        ctrl = '0;
        fq.delete();
        fifo_empty = 1'b1;
        exp_q.delete();
        cyc(2);
        chk("reset_ctl", {start, fifo_rd, frame_done, write, busy, sel, widx}, 0);
        chk("reset_bus", {address, data_wr}, 0);
        base = b;
        ctrl = {len, 14'd0, c, 1'b0};
    endtask

    task automatic run_scen(input vec_t t);
        int s0, r0, f0;
        logic [31:0] v;
        setup(t.base, t.len, t.cont);
        for (int i = 0; i < t.n; i++) begin
            v = $urandom;
            push(v);
            if (i < t.xs) exp_q.push_back('{t.base + 32'(i % int'(t.len)) * STEP, v});
        end
        s0 = n_start; r0 = n_rd; f0 = n_fd;
        rst_n = 1'b1;
        cyc(1);
        ctrl[0] = 1'b1;
        cyc(t.n * 12 + 30);
        chk("starts", n_start - s0, t.xs);
        chk("fifo_rds", n_rd - r0, t.xs);
        chk("frame_dones", n_fd - f0, t.xf);
        chk("busy_end", busy, 0);
        chk("word_index_end", widx, t.xi);
        chk("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        vec_t        r;
        int          s0, r0, f0;
        logic        found;
        logic [31:0] v;
        logic [31:0] w[4];
        fork
            mon();
            fifo_proc();
        join_none
        tbl[0] = '{32'h0000_1000, 16'd4, 1'b0, 4, 4, 1, 16'd0};
        tbl[1] = '{32'h0000_1000, 16'd2, 1'b1, 6, 6, 3, 16'd0};
        tbl[2] = '{32'hFFFF_FFFC, 16'd2, 1'b0, 2, 2, 1, 16'd0};
        tbl[3] = '{32'h0000_2000, 16'd3, 1'b0, 5, 3, 1, 16'd0};
        tbl[4] = '{32'h0000_7000, 16'd0, 1'b0, 2, 0, 0, 16'd0};
        tbl[5] = '{32'h0000_3000, 16'd1, 1'b1, 3, 3, 3, 16'd0};
        for (int i = 0; i < 6; i++) run_scen(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            r.base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'd3);
            r.len  = 16'($urandom_range(1, 4));
            r.cont = 1'($urandom_range(0, 1));
            r.n    = $urandom_range(1, 8);
            r.xs   = r.cont ? r.n : (r.n < int'(r.len) ? r.n : int'(r.len));
            r.xf   = r.cont ? r.n / int'(r.len) : int'(r.n >= int'(r.len));
            r.xi   = r.cont ? 16'(r.n % int'(r.len)) : (r.n >= int'(r.len) ? 16'd0 : 16'(r.n));
            run_scen(r);
        end

        // empty FIFO while armed, then a single push
        setup(32'h4000, 16'd2, 1'b0);
        s0 = n_start; r0 = n_rd;
        rst_n = 1'b1;
        cyc(1);
        ctrl[0] = 1'b1;
        cyc(10);
        chk("t3_idle_busy", busy, 0);
        chk("t3_no_rd", n_rd - r0, 0);
        chk("t3_no_start", n_start - s0, 0);
        v = $urandom;
        exp_q.push_back('{32'h4000, v});
        push(v);
        cyc(1);
        chk("t3_rd_at_idle1", fifo_rd, 1);
        cyc(1);
        chk("t3_latch_quiet", {fifo_rd, start}, 0);
        cyc(1);
        chk("t3_start_at_idle3", start, 1);
        cyc(15);
        chk("t3_word_index", widx, 1);
        chk("t3_busy_end", busy, 0);

        // enable dropped during WAIT_DONE of word 1
        setup(32'h5000, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            push(v);
            exp_q.push_back('{32'h5000 + 32'(i) * STEP, v});
        end
        s0 = n_start; r0 = n_rd; f0 = n_fd;
        rst_n = 1'b1;
        cyc(1);
        ctrl[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cyc(1);
            found = start && widx == 16'd1;
        end
        chk("t4_word1_started", found, 1);
        cyc(2);
        chk("t4_busy_wait_done", busy, 1);
        ctrl[0] = 1'b0;
        cyc(15);
        chk("t4_idx_retained", widx, 2);
        chk("t4_rd_count", n_rd - r0, 2);
        chk("t4_start_count", n_start - s0, 2);
        chk("t4_idle", busy, 0);
        ctrl[0] = 1'b1;
        cyc(40);
        chk("t4_resume_starts", n_start - s0, 4);
        chk("t4_frame_done", n_fd - f0, 1);
        chk("t4_idx_wrapped", widx, 0);
        chk("t4_exp_drained", exp_q.size(), 0);

        // reset during WAIT_ACT with active high
        setup(32'h6000, 16'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            push(w[i]);
        end
        exp_q.push_back('{32'h6000, w[0]});
        rst_n = 1'b1;
        cyc(1);
        ctrl[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            cyc(1);
            found = start;
        end
        chk("t5_started", found, 1);
        cyc(1);
        chk("t5_in_wait_act", {busy, active}, 2'b11);
        rst_n = 1'b0;
        cyc(1);
        chk("t5_reset_ctl", {start, fifo_rd, frame_done, write, busy, sel, widx}, 0);
        chk("t5_reset_bus", {address, data_wr}, 0);
        rst_n = 1'b1;
        s0 = n_start;
        cyc(20);
        chk("t5_no_restart", n_start - s0, 0);
        for (int i = 1; i < 4; i++) exp_q.push_back('{32'h6000 + 32'(i - 1) * STEP, w[i]});
        ctrl[0] = 1'b0;
        cyc(1);
        ctrl[0] = 1'b1;
        cyc(50);
        chk("t5_rearm_starts", n_start - s0, 3);
        chk("t5_exp_drained", exp_q.size(), 0);
        chk("t5_word_index", widx, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
